ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It is the opposite direction of the existing keyboard receive path.
- Lives beside the keyboard receiver unit and shares the same ps2d/ps2c open-drain pins.
- Performs request-to-send, shifts out 8 data bits plus odd parity on device-generated clock edges, releases data for the stop bit, and checks the device ACK.
- While tx_busy is high, the top level must hold off the receiver.

---
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 8 data bits + odd
// parity clocked out on device clock edges, stop bit release and ACK check.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 13000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2d,
   inout  wire        ps2c,
   output logic       tx_idle,
   output logic       tx_busy,
   output logic       tx_done_tick,
   output logic       tx_err
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_IDLE, DONE} state_t;

   state_t                state_q, state_d;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic                  fc_q, fc_d;
   logic                  fall_tick;
   logic [8:0]            sh_q, sh_d;
   logic [3:0]            n_q, n_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  drv_c, drv_d;

   // Filter is frozen while we pull ps2c low ourselves, so our own RTS never reads as a device edge.
   always_comb begin
      filt_d = filt_q;
      if (state_q != RTS)
         filt_d = {filt_q[FILTER_LEN-2:0], ps2c};
      fc_d = fc_q;
      if (&filt_q)
         fc_d = 1'b1;
      else if (~|filt_q)
         fc_d = 1'b0;
   end

   assign fall_tick = fc_q & ~fc_d;

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      n_d          = n_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      drv_c        = 1'b0;
      drv_d        = 1'b0;
      tx_done_tick = 1'b0;
      tx_err       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_ps2) begin
               sh_d    = {~^din, din};
               n_d     = '0;
               cnt_d   = INHIBIT_LOAD;
               err_d   = 1'b0;
               state_d = RTS;
            end
         end
         RTS: begin
            drv_c = 1'b1;
            drv_d = 1'b1;
            if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               state_d = START;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         START: begin
            drv_d = 1'b1;
            if (fall_tick)
               state_d = DATA;
         end
         DATA: begin
            drv_d = ~sh_q[0];
            if (fall_tick) begin
               if (n_q == 4'd8) begin
                  state_d = STOP;
               end else begin
                  sh_d = {1'b1, sh_q[8:1]};
                  n_d  = n_q + 4'd1;
               end
            end
         end
         STOP: begin
            if (fall_tick) begin
               err_d   = ps2d;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (fc_q && ps2d)
               state_d = DONE;
         end
         DONE: begin
            tx_done_tick = 1'b1;
            tx_err       = err_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An edge on the terminal-count cycle wins over the timeout.
      if (state_q inside {START, DATA, STOP, WAIT_IDLE}) begin
         if (fall_tick) begin
            cnt_d = '0;
         end else if (cnt_q == TMO_LAST) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         filt_q  <= '1;
         fc_q    <= 1'b1;
         n_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         fc_q    <= fc_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
      sh_q <= sh_d;
   end

   assign ps2c    = drv_c ? 1'b0 : 1'bz;
   assign ps2d    = drv_d ? 1'b0 : 1'bz;
   assign tx_idle = (state_q == IDLE);
   assign tx_busy = ~tx_idle;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on pulled-up open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH = 60;
   localparam int TMO = 400;
   localparam int FL  = 8;
   localparam int HP  = 25;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_ps2 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       tx_idle, tx_busy, tx_done_tick, tx_err;
   logic       dev_c = 1'b0;
   logic       dev_d = 1'b0;
   wire        ps2d_w;
   wire        ps2c_w;

   assign ps2c_w = dev_c ? 1'b0 : 1'bz;
   assign ps2d_w = dev_d ? 1'b0 : 1'bz;
   pullup (ps2c_w);
   pullup (ps2d_w);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO),
      .FILTER_LEN    (FL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_ps2      (wr_ps2),
      .din         (din),
      .ps2d        (ps2d_w),
      .ps2c        (ps2c_w),
      .tx_idle     (tx_idle),
      .tx_busy     (tx_busy),
      .tx_done_tick(tx_done_tick),
      .tx_err      (tx_err)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   done_cnt = 0;
   int   orphan_err = 0;
   logic last_err = 1'b0;

   always @(negedge clk) begin
      if (tx_done_tick) begin
         done_cnt = done_cnt + 1;
         last_err = tx_err;
      end else if (tx_err) begin
         orphan_err = orphan_err + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Request a transfer, then measure how long ps2c is held low and check the start bit.
   task automatic start_rts(input string tag, input logic [7:0] b);
      int lo;
      din    = b;
      wr_ps2 = 1'b1;
      tick();
      wr_ps2 = 1'b0;
      check({tag, "_c_low_1clk"}, 32'(ps2c_w), 32'd0);
      lo = 0;
      for (int i = 0; i < INH + 50; i++) begin
         if (ps2c_w !== 1'b0) break;
         lo++;
         tick();
      end
      check({tag, "_inhibit_len"}, 32'(lo), 32'(INH));
      check({tag, "_start_bit"}, 32'(ps2d_w), 32'd0);
   endtask

   // Device: n_edges clock pulses; samples data just before each rising edge; optional ACK.
   task automatic dev_frame(input int n_edges, input bit ack, output logic [9:0] rx);
      rx = '1;
      for (int e = 1; e <= n_edges; e++) begin
         repeat (HP) tick();
         dev_c = 1'b1;
         repeat (HP) tick();
         if (e <= 10) rx[e-1] = ps2d_w;
         dev_c = 1'b0;
         if (e == 10 && ack) begin
            repeat (4) tick();
            dev_d = 1'b1;
         end
         if (e == 11) begin
            repeat (4) tick();
            dev_d = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input string tag, input int base, input int limit);
      int k;
      k = 0;
      while (done_cnt == base && k < limit) begin
         tick();
         k++;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
   endtask

   logic [9:0] rx;
   int         base;
   int         k;

   initial begin
      repeat (3) tick();
      check("rst_idle", 32'(tx_idle), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done_tick), 32'd0);
      check("rst_err", 32'(tx_err), 32'd0);
      check("rst_ps2c", 32'(ps2c_w), 32'd1);
      check("rst_ps2d", 32'(ps2d_w), 32'd1);
      reset = 1'b0;
      repeat (20) tick();

      // 0xED with ACK: bits 1,0,1,1,0,1,1,1, parity 1
      base = done_cnt;
      start_rts("ed", 8'hED);
      check("ed_busy", 32'(tx_busy), 32'd1);
      dev_frame(11, 1'b1, rx);
      wait_done("ed", base, 200);
      check("ed_err", 32'(last_err), 32'd0);
      check("ed_data", 32'(rx[7:0]), 32'h0000_00ED);
      check("ed_parity", 32'(rx[8]), 32'd1);
      check("ed_stop", 32'(rx[9]), 32'd1);
      repeat (20) tick();
      check("ed_one_done", 32'(done_cnt - base), 32'd1);
      check("ed_idle", 32'(tx_idle), 32'd1);

      // 0x01: parity 0
      base = done_cnt;
      start_rts("x01", 8'h01);
      dev_frame(11, 1'b1, rx);
      wait_done("x01", base, 200);
      check("x01_data", 32'(rx[7:0]), 32'h0000_0001);
      check("x01_parity", 32'(rx[8]), 32'd0);
      check("x01_err", 32'(last_err), 32'd0);
      repeat (20) tick();

      // 0xFF with no ACK from the device
      base = done_cnt;
      start_rts("ff", 8'hFF);
      dev_frame(11, 1'b0, rx);
      wait_done("ff", base, 200);
      check("ff_err", 32'(last_err), 32'd1);
      check("ff_parity", 32'(rx[8]), 32'd1);
      tick();
      check("ff_ps2c_rel", 32'(ps2c_w), 32'd1);
      check("ff_ps2d_rel", 32'(ps2d_w), 32'd1);
      repeat (20) tick();

      // Device stops after 4 edges while host drives bit3 = 0 of 0xA0
      base = done_cnt;
      start_rts("tmo", 8'hA0);
      dev_frame(4, 1'b0, rx);
      check("tmo_bit3_driven", 32'(ps2d_w), 32'd0);
      k = 0;
      while (done_cnt == base && k < TMO + 200) begin
         tick();
         k++;
      end
      check("tmo_done_seen", 32'(done_cnt != base), 32'd1);
      check("tmo_window", 32'(k >= TMO - HP && k <= TMO - HP + FL + 4), 32'd1);
      check("tmo_err", 32'(last_err), 32'd1);
      tick();
      check("tmo_ps2c_rel", 32'(ps2c_w), 32'd1);
      check("tmo_ps2d_rel", 32'(ps2d_w), 32'd1);
      check("tmo_idle", 32'(tx_idle), 32'd1);
      repeat (20) tick();

      // wr_ps2 with 0x55 during DATA of an 0xED transfer is ignored
      base = done_cnt;
      start_rts("ign", 8'hED);
      fork
         dev_frame(11, 1'b1, rx);
         begin
            repeat (6 * HP) tick();
            din    = 8'h55;
            wr_ps2 = 1'b1;
            tick();
            wr_ps2 = 1'b0;
         end
      join
      wait_done("ign", base, 200);
      check("ign_data", 32'(rx[7:0]), 32'h0000_00ED);
      check("ign_err", 32'(last_err), 32'd0);
      repeat (200) tick();
      check("ign_one_done", 32'(done_cnt - base), 32'd1);
      check("ign_idle", 32'(tx_idle), 32'd1);
      check("ign_ps2c_high", 32'(ps2c_w), 32'd1);

      // Reset during RTS
      base = done_cnt;
      din    = 8'h12;
      wr_ps2 = 1'b1;
      tick();
      wr_ps2 = 1'b0;
      repeat (10) tick();
      check("rrts_in_rts", 32'(ps2c_w), 32'd0);
      reset = 1'b1;
      tick();
      check("rrts_ps2c", 32'(ps2c_w), 32'd1);
      check("rrts_ps2d", 32'(ps2d_w), 32'd1);
      check("rrts_idle", 32'(tx_idle), 32'd1);
      check("rrts_busy", 32'(tx_busy), 32'd0);
      reset = 1'b0;
      repeat (100) tick();
      check("rrts_no_done", 32'(done_cnt - base), 32'd0);

      // Reset during DATA while host drives a 0 bit of 0x00
      base = done_cnt;
      start_rts("rdat", 8'h00);
      dev_frame(3, 1'b0, rx);
      check("rdat_bit_driven", 32'(ps2d_w), 32'd0);
      reset = 1'b1;
      tick();
      check("rdat_ps2c", 32'(ps2c_w), 32'd1);
      check("rdat_ps2d", 32'(ps2d_w), 32'd1);
      check("rdat_idle", 32'(tx_idle), 32'd1);
      reset = 1'b0;
      repeat (TMO + 50) tick();
      check("rdat_no_done", 32'(done_cnt - base), 32'd0);
      check("no_orphan_err", 32'(orphan_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
